// File: rtl/icache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_fill_ctrl
//
// Purpose:
//   Direct-mapped instruction cache with a single outstanding line fill.
//   A fetch PC is looked up combinationally. On a miss, the controller
//   requests the whole line from memory and writes the returned words in
//   ascending order. The line is validated only if the burst had no bus
//   error and no FLUSH occurred while the fill was in flight.
//
// Parameters:
//   SETS  - number of lines (power of two, >= 2)
//   WORDS - 32-bit words per line (power of two, >= 2)
//
// Ports:
//   CLK          in   sole clock, rising edge
//   RESET_N      in   synchronous active-low reset
//   PC           in   64-bit fetch address
//   FLUSH        in   invalidate all lines (fence.i)
//   ICACHE_R     out  instruction valid for current PC (combinational hit)
//   INSTRUCTION  out  word for PC on hit, NOP (32'h00000013) otherwise
//   ICACHE_ERR   out  one-cycle pulse after a fill that saw MEM_ERR
//   MEM_REQ      out  line-fill request, held until MEM_ACK
//   MEM_ADDR     out  line-aligned fill address
//   MEM_ACK      in   memory accepts the request
//   MEM_RVALID   in   return word valid
//   MEM_RDATA    in   return word, ascending address order
//   MEM_ERR      in   bus error, qualified by MEM_RVALID
//   HIT_CNT      out  hit counter (cycles with a hit)
//   MISS_CNT     out  miss counter (fills started)
//
// Configuration:
//   ICACHE_PERF_EN - when defined, HIT_CNT/MISS_CNT are live counters;
//                    otherwise both are tied to zero with no counter flops.
// ---------------------------------------------------------------------------
module icache_fill_ctrl #(
   parameter int unsigned SETS  = 32,
   parameter int unsigned WORDS = 4
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [63:0] PC,
   input  logic        FLUSH,
   output logic        ICACHE_R,
   output logic [31:0] INSTRUCTION,
   output logic        ICACHE_ERR,
   output logic        MEM_REQ,
   output logic [63:0] MEM_ADDR,
   input  logic        MEM_ACK,
   input  logic        MEM_RVALID,
   input  logic [31:0] MEM_RDATA,
   input  logic        MEM_ERR,
   output logic [31:0] HIT_CNT,
   output logic [31:0] MISS_CNT
);

   localparam int unsigned OFF_W   = $clog2(WORDS);
   localparam int unsigned IDX_W   = $clog2(SETS);
   localparam int unsigned TAG_LSB = OFF_W + IDX_W + 2;
   localparam int unsigned TAG_W   = 64 - TAG_LSB;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FILL
   } state_t;

   state_t             r_state;
   state_t             w_next_state;

   logic [SETS-1:0]    r_valid;
   logic [TAG_W-1:0]   r_tag  [SETS];
   logic [31:0]        r_data [SETS][WORDS];

   logic [IDX_W-1:0]   r_idx;
   logic [OFF_W-1:0]   r_cnt;
   logic               r_mem_req;
   logic [63:0]        r_mem_addr;
   logic               r_err_pulse;
   logic               r_err_acc;
   logic               r_flush_pend;

   logic [OFF_W-1:0]   w_off;
   logic [IDX_W-1:0]   w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic               w_aligned;
   logic               w_hit;
   logic               w_miss;
   logic               w_beat;
   logic               w_last;
   logic               w_burst_err;
   logic               w_flush_any;

   // ------------------------------------------------------------------------
   // Address decomposition and lookup
   // ------------------------------------------------------------------------
   assign w_off     = PC[OFF_W+1:2];
   assign w_idx     = PC[TAG_LSB-1:OFF_W+2];
   assign w_tag     = PC[63:TAG_LSB];
   assign w_aligned = (PC[1:0] == 2'b00);

   // FLUSH masks the hit so a fetch never consumes a line being invalidated.
   assign w_hit  = (r_state == IDLE) && w_aligned && !FLUSH &&
                   r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_miss = (r_state == IDLE) && w_aligned && !w_hit && !FLUSH;

   assign ICACHE_R    = w_hit;
   assign INSTRUCTION = w_hit ? r_data[w_idx][w_off] : NOP;

   // ------------------------------------------------------------------------
   // Fill beat bookkeeping
   // ------------------------------------------------------------------------
   assign w_beat      = (r_state == FILL) && MEM_RVALID;
   assign w_last      = w_beat && (r_cnt == OFF_W'(WORDS - 1));
   // Include the current beat so an error on the final word still counts.
   assign w_burst_err = r_err_acc | MEM_ERR;
   assign w_flush_any = r_flush_pend | FLUSH;

   assign MEM_REQ    = r_mem_req;
   assign MEM_ADDR   = r_mem_addr;
   assign ICACHE_ERR = r_err_pulse;

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_miss)               w_next_state = REQ;
         REQ:     if (r_mem_req && MEM_ACK) w_next_state = FILL;
         FILL:    if (w_last)               w_next_state = IDLE;
         default:                           w_next_state = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM state register and control flops
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         r_state      <= IDLE;
         r_valid      <= '0;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_mem_req    <= 1'b0;
         r_mem_addr   <= '0;
         r_err_pulse  <= 1'b0;
         r_err_acc    <= 1'b0;
         r_flush_pend <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_err_pulse <= w_last && w_burst_err;

         if (w_miss) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= {PC[63:OFF_W+2], {(OFF_W+2){1'b0}}};
            r_idx      <= w_idx;
         end else if ((r_state == REQ) && MEM_ACK) begin
            r_mem_req  <= 1'b0;
         end

         // Counter wraps to zero on the final beat since WORDS is 2^OFF_W.
         if (w_beat) begin
            r_cnt     <= r_cnt + OFF_W'(1);
            r_err_acc <= w_last ? 1'b0 : w_burst_err;
         end

         // A flush seen mid-fill is remembered and applied at completion.
         if (w_last)
            r_flush_pend <= 1'b0;
         else if ((r_state != IDLE) && FLUSH)
            r_flush_pend <= 1'b1;

         // The target line is invalidated at the miss edge, i.e. as REQ is
         // entered, so a failed fill leaves it invalid without extra work.
         if ((r_state == IDLE) && FLUSH) begin
            r_valid <= '0;
         end else if (w_miss) begin
            r_valid[w_idx] <= 1'b0;
         end else if (w_last) begin
            if (w_flush_any)
               r_valid <= '0;
            else if (!w_burst_err)
               r_valid[r_idx] <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Tag and data arrays (not reset)
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET_N && w_beat)
         r_data[r_idx][r_cnt] <= MEM_RDATA;
      if (RESET_N && w_last && !w_burst_err && !w_flush_any)
         r_tag[r_idx] <= r_mem_addr[63:TAG_LSB];
   end

   // ------------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------------
`ifdef ICACHE_PERF_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_hit)  r_hit_cnt  <= r_hit_cnt + 32'd1;
         if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign HIT_CNT  = r_hit_cnt;
   assign MISS_CNT = r_miss_cnt;
`else
   assign HIT_CNT  = '0;
   assign MISS_CNT = '0;
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_icache_fill_ctrl
//
// Directed bench for icache_fill_ctrl (SETS=32, WORDS=4). Memory returns
// word 32'hCAFE0000 + addr[15:0] for each beat, so expected instructions
// are written as literals. Scenarios: reset state, cold miss, line reuse,
// misaligned PC with a stray return beat, conflict eviction, bus error,
// FLUSH during a fill, FLUSH while idle.
// ---------------------------------------------------------------------------
module tb_icache_fill_ctrl;

   localparam int unsigned WORDS = 4;

   logic        CLK;
   logic        RESET_N;
   logic [63:0] PC;
   logic        FLUSH;
   logic        ICACHE_R;
   logic [31:0] INSTRUCTION;
   logic        ICACHE_ERR;
   logic        MEM_REQ;
   logic [63:0] MEM_ADDR;
   logic        MEM_ACK;
   logic        MEM_RVALID;
   logic [31:0] MEM_RDATA;
   logic        MEM_ERR;
   logic [31:0] HIT_CNT;
   logic [31:0] MISS_CNT;

   int n_tests  = 0;
   int n_fail   = 0;
   int exp_miss = 0;

   icache_fill_ctrl #(
      .SETS  (32),
      .WORDS (WORDS)
   ) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .PC          (PC),
      .FLUSH       (FLUSH),
      .ICACHE_R    (ICACHE_R),
      .INSTRUCTION (INSTRUCTION),
      .ICACHE_ERR  (ICACHE_ERR),
      .MEM_REQ     (MEM_REQ),
      .MEM_ADDR    (MEM_ADDR),
      .MEM_ACK     (MEM_ACK),
      .MEM_RVALID  (MEM_RVALID),
      .MEM_RDATA   (MEM_RDATA),
      .MEM_ERR     (MEM_ERR),
      .HIT_CNT     (HIT_CNT),
      .MISS_CNT    (MISS_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_miss_cnt(input string tag);
`ifdef ICACHE_PERF_EN
      chk(tag, {32'h0, MISS_CNT}, 64'(exp_miss));
`else
      chk(tag, {32'h0, MISS_CNT}, 64'h0);
`endif
   endtask

   // Serves one line fill: waits (bounded) for MEM_REQ, acks, returns WORDS
   // beats. err_beat/flush_beat select a beat carrying MEM_ERR / FLUSH (-1 none).
   task automatic fill_line(input logic [63:0] base, input int err_beat, input int flush_beat);
      int k;
      k = 0;
      while (MEM_REQ !== 1'b1 && k < 8) begin
         step();
         k++;
      end
      chk("req_seen", {63'h0, MEM_REQ}, 64'h1);
      chk("req_addr", MEM_ADDR, base);
      exp_miss++;
      MEM_ACK = 1'b1;
      step();
      MEM_ACK = 1'b0;
      chk("req_drop", {63'h0, MEM_REQ}, 64'h0);
      for (int i = 0; i < int'(WORDS); i++) begin
         MEM_RVALID = 1'b1;
         MEM_RDATA  = 32'hCAFE0000 + {16'h0, base[15:0]} + 32'(4 * i);
         MEM_ERR    = (i == err_beat);
         FLUSH      = (i == flush_beat);
         #1;
         chk("fill_r0", {63'h0, ICACHE_R}, 64'h0);
         step();
      end
      MEM_RVALID = 1'b0;
      MEM_ERR    = 1'b0;
      FLUSH      = 1'b0;
   endtask

   task automatic chk_hit(input string tag, input logic [31:0] instr);
      #1;
      chk({tag, "_r"},    {63'h0, ICACHE_R}, 64'h1);
      chk({tag, "_inst"}, {32'h0, INSTRUCTION}, {32'h0, instr});
   endtask

   task automatic chk_nohit(input string tag);
      #1;
      chk({tag, "_r"},    {63'h0, ICACHE_R}, 64'h0);
      chk({tag, "_inst"}, {32'h0, INSTRUCTION}, 64'h13);
   endtask

   initial begin
      RESET_N    = 1'b0;
      PC         = 64'h0;
      FLUSH      = 1'b0;
      MEM_ACK    = 1'b0;
      MEM_RVALID = 1'b0;
      MEM_RDATA  = 32'h0;
      MEM_ERR    = 1'b0;
      step();
      step();

      // Reset state
      #1;
      chk("rst_req",  {63'h0, MEM_REQ}, 64'h0);
      chk("rst_addr", MEM_ADDR, 64'h0);
      chk("rst_err",  {63'h0, ICACHE_ERR}, 64'h0);
      chk("rst_hit",  {32'h0, HIT_CNT}, 64'h0);
      chk("rst_miss", {32'h0, MISS_CNT}, 64'h0);
      chk_nohit("rst");

      // Cold miss at 0x1000
      RESET_N = 1'b1;
      PC      = 64'h1000;
      #1;
      chk("cold_r0",   {63'h0, ICACHE_R}, 64'h0);
      chk("cold_req0", {63'h0, MEM_REQ}, 64'h0);
      step();
      chk("cold_req1",  {63'h0, MEM_REQ}, 64'h1);
      chk("cold_addr1", MEM_ADDR, 64'h1000);
      chk("cold_r_req", {63'h0, ICACHE_R}, 64'h0);
      step();
      chk("cold_req_hold",  {63'h0, MEM_REQ}, 64'h1);
      chk("cold_addr_hold", MEM_ADDR, 64'h1000);
      fill_line(64'h1000, -1, -1);
      chk_hit("cold_hit", 32'hCAFE1000);
      chk("cold_noerr", {63'h0, ICACHE_ERR}, 64'h0);

      // Line reuse
      for (int i = 1; i < 4; i++) begin
         PC = 64'h1000 + 64'(4 * i);
         chk_hit("reuse", 32'hCAFE1000 + 32'(4 * i));
         step();
         chk("reuse_noreq", {63'h0, MEM_REQ}, 64'h0);
      end

      // Misaligned PC, with a stray return beat while idle
      PC         = 64'h1002;
      MEM_RVALID = 1'b1;
      MEM_RDATA  = 32'hDEADBEEF;
      chk_nohit("misal");
      step();
      chk("misal_noreq1", {63'h0, MEM_REQ}, 64'h0);
      step();
      chk("misal_noreq2", {63'h0, MEM_REQ}, 64'h0);
      chk_miss_cnt("misal_misscnt");
      MEM_RVALID = 1'b0;
      PC         = 64'h1000;
      chk_hit("stray_ignored", 32'hCAFE1000);

      // Conflict eviction: 0x1200 maps to the same index as 0x1000
      PC = 64'h1200;
      chk_nohit("conf_miss");
      fill_line(64'h1200, -1, -1);
      chk_hit("conf_hit", 32'hCAFE1200);
      PC = 64'h1000;
      chk_nohit("conf_evicted");
      fill_line(64'h1000, -1, -1);
      chk_hit("conf_refill", 32'hCAFE1000);

      // Bus error on beat 2 of the 0x2000 fill
      PC = 64'h2000;
      chk_nohit("berr_miss");
      fill_line(64'h2000, 2, -1);
      #1;
      chk("berr_pulse", {63'h0, ICACHE_ERR}, 64'h1);
      chk("berr_inval", {63'h0, ICACHE_R}, 64'h0);
      step();
      chk("berr_pulse_once", {63'h0, ICACHE_ERR}, 64'h0);
      chk("berr_refetch",    {63'h0, MEM_REQ}, 64'h1);
      chk("berr_refaddr",    MEM_ADDR, 64'h2000);
      fill_line(64'h2000, -1, -1);
      chk_hit("berr_recover", 32'hCAFE2000);
      chk("berr_noerr2", {63'h0, ICACHE_ERR}, 64'h0);

      // FLUSH during FILL
      PC = 64'h1010;
      fill_line(64'h1010, -1, -1);
      chk_hit("fl_pre", 32'hCAFE1010);
      PC = 64'h1020;
      fill_line(64'h1020, -1, 1);
      PC = 64'h1010;
      chk_nohit("fl_other_inval");
      fill_line(64'h1010, -1, -1);
      PC = 64'h1000;
      chk_nohit("fl_1000_miss");
      fill_line(64'h1000, -1, -1);
      chk_hit("fl_refill", 32'hCAFE1000);

      // FLUSH while idle
      FLUSH = 1'b1;
      chk_nohit("flidle_cycle");
      step();
      FLUSH = 1'b0;
      chk_nohit("flidle_after");
      chk("flidle_noreq", {63'h0, MEM_REQ}, 64'h0);
      fill_line(64'h1000, -1, -1);
      chk_hit("flidle_refill", 32'hCAFE1000);

      chk_miss_cnt("end_misscnt");
`ifndef ICACHE_PERF_EN
      chk("end_hitcnt", {32'h0, HIT_CNT}, 64'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
